// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting one packed patch per fully-inside window position.
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 16
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  output logic [9*PIX_W-1:0] PATCH,
  output logic               patch_valid,
  input  logic               patch_ready,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]      col, col_p0;
  logic [RW-1:0]      row, row_p0;
  logic               acc_p0, win_ok_p0;
  logic [PIX_W-1:0]   top_p0, mid_p0;
  logic [9*PIX_W-1:0] patch_nxt_p0, patch_p1;
  logic               vld_p1, done_p1;

  logic [PIX_W-1:0]   lb0 [IMG_W];
  logic [PIX_W-1:0]   lb1 [IMG_W];
  logic [PIX_W-1:0]   win [3][3];

  // Stage p0: accept, position decode and line-buffer read
  assign in_ready  = !vld_p1 || patch_ready;
  assign acc_p0    = in_valid && in_ready;
  // An accepted start-of-frame pixel is placed at (0,0) regardless of counters
  assign col_p0    = in_sof ? '0 : col;
  assign row_p0    = in_sof ? '0 : row;
  assign win_ok_p0 = (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
  assign top_p0    = lb1[col_p0];
  assign mid_p0    = lb0[col_p0];

  always_comb begin
    patch_nxt_p0 = {win[0][1], win[0][2], top_p0,
                    win[1][1], win[1][2], mid_p0,
                    win[2][1], win[2][2], in_pixel};
  end

  always_ff @(posedge CLK) begin
    if (acc_p0) begin
      lb1[col_p0] <= lb0[col_p0];
      lb0[col_p0] <= in_pixel;
    end
  end

  always_ff @(posedge CLK) begin
    if (acc_p0) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= top_p0;
      win[1][2] <= mid_p0;
      win[2][2] <= in_pixel;
    end
  end

  // Stage p1: registered patch, counters and frame-done pulse
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      vld_p1   <= 1'b0;
      patch_p1 <= '0;
      done_p1  <= 1'b0;
    end else begin
      done_p1 <= 1'b0;
      if (acc_p0) begin
        if (col_p0 == COL_LAST) begin
          col <= '0;
          if (row_p0 == ROW_LAST) begin
            row     <= '0;
            done_p1 <= 1'b1;
          end else begin
            row <= row_p0 + RW'(1);
          end
        end else begin
          col <= col_p0 + CW'(1);
          row <= row_p0;
        end
      end
      if (acc_p0 && win_ok_p0) begin
        patch_p1 <= patch_nxt_p0;
        vld_p1   <= 1'b1;
      end else if (patch_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign PATCH       = patch_p1;
  assign patch_valid = vld_p1;
  assign frame_done  = done_p1;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 image with directed frames.
module tb_conv_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int P  = 16;
  localparam int PW = 9 * P;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic [P-1:0]  in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          patch_ready = 1'b1;
  logic          in_ready;
  logic [PW-1:0] PATCH;
  logic          patch_valid;
  logic          frame_done;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .CLK(CLK), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .PATCH(PATCH),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            fd_cnt = 0;
  logic [PW-1:0] exp_q [$];
  bit            lat_chk = 0;
  bit            rnd_valid = 0;
  bit            bub_done = 0;

  // Hand-computed windows of the 4x4 frame with pixel = 4*row+col+1
  int tab [4][9] = '{'{1, 2, 3, 5, 6, 7, 9, 10, 11},
                     '{2, 3, 4, 6, 7, 8, 10, 11, 12},
                     '{5, 6, 7, 9, 10, 11, 13, 14, 15},
                     '{6, 7, 8, 10, 11, 12, 14, 15, 16}};

  function automatic logic [PW-1:0] pack(input int k, input int off);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[PW-P-1:0], P'(tab[k][i] + off)};
    return v;
  endfunction

  task automatic check_patch(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rst_n && patch_valid && patch_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_patch: got %h expected none", PATCH);
      end else begin
        check_patch("patch", PATCH, exp_q.pop_front());
      end
    end
  end

  always @(negedge CLK) if (rst_n && frame_done) fd_cnt++;

  task automatic send_pixel(input logic [P-1:0] v, input logic sof);
    bit acc;
    int t;
    t = 0;
    if (rnd_valid && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = 16'hdead;
      @(posedge CLK); #1;
    end
    in_pixel = v;
    in_valid = 1'b1;
    in_sof   = sof;
    forever begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK); #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
  endtask

  task automatic send_frame(input int off, input logic sof, input int npix);
    int n;
    n = 0;
    if (npix == W * H) for (int k = 0; k < 4; k++) exp_q.push_back(pack(k, off));
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          send_pixel(P'(4 * r + c + 1 + off), sof && r == 0 && c == 0);
          if (lat_chk) begin
            check_int($sformatf("patch_valid_after_px%0d", n + 1), int'(patch_valid),
                      int'(r >= 2 && c >= 2));
            check_int($sformatf("frame_done_after_px%0d", n + 1), int'(frame_done),
                      int'(r == H - 1 && c == W - 1));
          end
        end
        n++;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || patch_valid) && t < 200) begin
      @(posedge CLK); #1;
      t++;
    end
    repeat (2) @(posedge CLK);
    #1;
    check_int({name, "_patches_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_patch_valid", int'(patch_valid), 0);
    check_patch("reset_patch", PATCH, '0);
    check_int("reset_frame_done", int'(frame_done), 0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;

    // basic frame with latency and frame_done timing checks
    fd_cnt = 0;
    lat_chk = 1;
    send_frame(0, 1'b1, W * H);
    lat_chk = 0;
    drain("basic");
    check_int("basic_frame_done_count", fd_cnt, 1);

    // backpressure on the first patch
    fd_cnt = 0;
    fork
      send_frame(0, 1'b1, W * H);
      begin
        int t;
        t = 0;
        do begin
          @(posedge CLK); #1;
          t++;
        end while (!patch_valid && t < 100);
        patch_ready = 1'b0;
        repeat (5) begin
          @(negedge CLK);
          check_int("bp_patch_valid", int'(patch_valid), 1);
          check_int("bp_in_ready", int'(in_ready), 0);
          check_patch("bp_patch_hold", PATCH, pack(0, 0));
          @(posedge CLK); #1;
        end
        patch_ready = 1'b1;
      end
    join
    drain("backpressure");
    check_int("bp_frame_done_count", fd_cnt, 1);

    // back-to-back frames, second one without in_sof
    fd_cnt = 0;
    send_frame(0, 1'b1, W * H);
    send_frame(100, 1'b0, W * H);
    drain("b2b");
    check_int("b2b_frame_done_count", fd_cnt, 2);

    // mid-frame resync
    fd_cnt = 0;
    send_frame(0, 1'b1, 6);
    send_frame(0, 1'b1, W * H);
    drain("resync");
    check_int("resync_frame_done_count", fd_cnt, 1);

    // asynchronous reset mid-frame, then a frame without in_sof
    fd_cnt = 0;
    send_frame(0, 1'b1, 10);
    patch_ready = 1'b0;
    @(posedge CLK);
    #3 rst_n = 1'b0;
    #1;
    check_int("midrst_patch_valid", int'(patch_valid), 0);
    check_int("midrst_in_ready", int'(in_ready), 1);
    check_patch("midrst_patch", PATCH, '0);
    check_int("midrst_frame_done", int'(frame_done), 0);
    @(posedge CLK);
    #1 rst_n = 1'b1;
    patch_ready = 1'b1;
    send_frame(0, 1'b0, W * H);
    drain("midrst");
    check_int("midrst_frame_done_count", fd_cnt, 1);

    // bubbles on input and random output readiness
    fd_cnt = 0;
    rnd_valid = 1;
    bub_done = 0;
    fork
      begin
        send_frame(0, 1'b1, W * H);
        bub_done = 1;
      end
      begin
        while (!bub_done) begin
          @(posedge CLK); #1;
          patch_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    rnd_valid = 0;
    patch_ready = 1'b1;
    drain("bubbles");
    check_int("bubbles_frame_done_count", fd_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
